// File: rtl/gpio_strap_pkg.sv
// Shared FSM state encoding and default parameter values for the strap sampler.
package gpio_strap_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_TRACK   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } strap_state_e;

    localparam int unsigned DEF_WIDTH          = 32;
    localparam int unsigned DEF_SETTLE_CYCLES  = 16;
    localparam int unsigned DEF_STABLE_CYCLES  = 8;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/gpio_strap_sampler_sync.sv
// WIDTH-wide two-flop synchroniser for asynchronous pad inputs, synchronous reset to zero.
module gpio_sync2 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Two-stage capture of the raw pads; both stages cleared by reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/gpio_strap_sampler.sv
// Strap sampler: enables strap pads, waits for them to settle, then captures the
// synchronised gpio value once stable for STABLE_CYCLES (or forced by timeout).
module gpio_strap_sampler
    import gpio_strap_pkg::*;
#(
    parameter int unsigned WIDTH          = DEF_WIDTH,
    parameter int unsigned SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
    parameter int unsigned STABLE_CYCLES  = DEF_STABLE_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic             PCLK,
    input  logic             PRESET,
    input  logic [WIDTH-1:0] gpio_in,
    input  logic             strap_resample,
    output logic             strap_en,
    output logic             strap_sample_valid,
    output logic [WIDTH-1:0] strap_sample_data,
    output logic             strap_timeout,
    output logic             strap_busy
);

    localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned RW = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    strap_state_e     r_state;
    strap_state_e     w_next;

    logic [WIDTH-1:0] w_sample;
    logic [WIDTH-1:0] r_prev;

    logic [SW-1:0]    r_scnt;
    logic [SW-1:0]    w_scnt;
    logic [RW-1:0]    r_run;
    logic [RW-1:0]    w_run;
    logic [TW-1:0]    r_tcnt;
    logic [TW-1:0]    w_tcnt;
    logic             w_cap_to;

    logic             r_en;
    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             r_timeout;
    logic             r_busy;

    gpio_sync2 #(
        .WIDTH(WIDTH)
    ) u_sync (
        .i_clk (PCLK),
        .i_rst (PRESET),
        .i_d   (gpio_in),
        .o_q   (w_sample)
    );

    // State register.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic plus the count values for the current cycle.
    // Counters hold zero outside their state, so zero marks the first cycle of a state.
    always_comb begin
        w_next   = r_state;
        w_cap_to = 1'b0;
        w_scnt   = (r_scnt == SW'(SETTLE_CYCLES)) ? r_scnt : r_scnt + SW'(1);
        w_tcnt   = (r_tcnt == TW'(TIMEOUT_CYCLES)) ? r_tcnt : r_tcnt + TW'(1);
        if ((r_run == '0) || (w_sample != r_prev)) begin
            w_run = RW'(1);
        end else if (r_run == RW'(STABLE_CYCLES)) begin
            w_run = r_run;
        end else begin
            w_run = r_run + RW'(1);
        end

        case (r_state)
            ST_IDLE: begin
                w_next = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (w_scnt == SW'(SETTLE_CYCLES)) begin
                    w_next = ST_TRACK;
                end
            end
            ST_TRACK: begin
                if (w_run == RW'(STABLE_CYCLES)) begin
                    w_next = ST_CAPTURE;
                end else if (w_tcnt == TW'(TIMEOUT_CYCLES)) begin
                    w_next   = ST_CAPTURE;
                    w_cap_to = 1'b1;
                end
            end
            ST_CAPTURE: begin
                w_next = ST_DONE;
            end
            ST_DONE: begin
                if (strap_resample) begin
                    w_next = ST_SETTLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Counters, previous sample, capture registers and outputs registered from the next state.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_prev    <= '0;
            r_scnt    <= '0;
            r_run     <= '0;
            r_tcnt    <= '0;
            r_en      <= 1'b0;
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_timeout <= 1'b0;
            r_busy    <= 1'b1;
        end else begin
            r_prev <= w_sample;
            r_scnt <= (r_state == ST_SETTLE) ? w_scnt : '0;
            r_run  <= (r_state == ST_TRACK)  ? w_run  : '0;
            r_tcnt <= (r_state == ST_TRACK)  ? w_tcnt : '0;

            r_en    <= (w_next == ST_SETTLE) || (w_next == ST_TRACK);
            r_valid <= (w_next == ST_CAPTURE);
            r_busy  <= (w_next != ST_DONE);

            if ((r_state == ST_TRACK) && (w_next == ST_CAPTURE)) begin
                r_data    <= w_sample;
                r_timeout <= w_cap_to;
            end
        end
    end

    assign strap_en           = r_en;
    assign strap_sample_valid = r_valid;
    assign strap_sample_data  = r_data;
    assign strap_timeout      = r_timeout;
    assign strap_busy         = r_busy;

endmodule

// File: tb/tb_gpio_strap_sampler.sv
// Scoreboard bench for gpio_strap_sampler: directed scenarios push expected captures,
// a negedge monitor pops and compares on every valid pulse.
module tb_gpio_strap_sampler;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic [31:0] gpio_in;
    logic        strap_resample;
    logic        strap_en;
    logic        strap_sample_valid;
    logic [31:0] strap_sample_data;
    logic        strap_timeout;
    logic        strap_busy;

    typedef struct {
        logic [31:0] data;
        logic        to;
        int unsigned edge_n;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int unsigned ecnt  = 0;

    always #5 PCLK = ~PCLK;

    gpio_strap_sampler #(
        .WIDTH          (32),
        .SETTLE_CYCLES  (16),
        .STABLE_CYCLES  (8),
        .TIMEOUT_CYCLES (1024)
    ) dut (
        .PCLK               (PCLK),
        .PRESET             (PRESET),
        .gpio_in            (gpio_in),
        .strap_resample     (strap_resample),
        .strap_en           (strap_en),
        .strap_sample_valid (strap_sample_valid),
        .strap_sample_data  (strap_sample_data),
        .strap_timeout      (strap_timeout),
        .strap_busy         (strap_busy)
    );

    // Edge number since reset release: edge 1 is the first rising edge with PRESET low.
    always @(posedge PCLK) begin
        if (PRESET) ecnt <= 0;
        else        ecnt <= ecnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h (edge %0d)", name, act, exp, ecnt);
        end
    endtask

    // Monitor: every valid pulse must match the oldest expected capture.
    always @(negedge PCLK) begin
        if (strap_sample_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_valid: got valid=1 at edge %0d required no pulse", ecnt);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("valid_edge", 32'(ecnt), 32'(e.edge_n));
                check("valid_data", strap_sample_data, e.data);
                check("valid_timeout", 32'(strap_timeout), 32'(e.to));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    task automatic wait_edge(input int unsigned e);
        int g;
        g = 0;
        while ((ecnt < e) && (g < 5000)) begin
            tick(1);
            g++;
        end
        check("wait_edge_bound", 32'(ecnt), 32'(e));
    endtask

    task automatic do_reset();
        PRESET         = 1'b1;
        strap_resample = 1'b0;
        tick(3);
        check("rst_en", 32'(strap_en), 32'd0);
        check("rst_valid", 32'(strap_sample_valid), 32'd0);
        check("rst_busy", 32'(strap_busy), 32'd1);
        check("rst_data", strap_sample_data, 32'd0);
        check("rst_timeout", 32'(strap_timeout), 32'd0);
        PRESET = 1'b0;
    endtask

    initial begin
        int unsigned r;

        // Scenario 1: constant pads, nominal latency.
        gpio_in = 32'hA5A5_0F0F;
        do_reset();
        sb.push_back('{data: 32'hA5A5_0F0F, to: 1'b0, edge_n: 25});
        while (ecnt < 28) begin
            tick(1);
            check("s1_en", 32'(strap_en), 32'((ecnt >= 1) && (ecnt <= 24)));
            check("s1_busy", 32'(strap_busy), 32'(ecnt <= 25));
        end
        check("s1_pending", 32'(sb.size()), 32'd0);
        check("s1_hold_data", strap_sample_data, 32'hA5A5_0F0F);

        // Scenario 5: reset in TRACK aborts, then the sequence reruns cleanly.
        do_reset();
        wait_edge(20);
        PRESET = 1'b1;
        tick(1);
        check("s5_en", 32'(strap_en), 32'd0);
        check("s5_valid", 32'(strap_sample_valid), 32'd0);
        check("s5_busy", 32'(strap_busy), 32'd1);
        check("s5_data", strap_sample_data, 32'd0);
        check("s5_timeout", 32'(strap_timeout), 32'd0);
        PRESET = 1'b0;
        sb.push_back('{data: 32'hA5A5_0F0F, to: 1'b0, edge_n: 25});
        wait_edge(28);
        check("s5_pending", 32'(sb.size()), 32'd0);
        check("s5_busy_done", 32'(strap_busy), 32'd0);

        // Scenario 2: pads toggle every cycle. Value driven after edge k is all-ones for even k;
        // the sample seen at capture edge 1041 entered the synchroniser at edge 1039 (driven after 1038).
        do_reset();
        sb.push_back('{data: 32'hFFFF_FFFF, to: 1'b1, edge_n: 1041});
        while (ecnt < 1044) begin
            gpio_in = ecnt[0] ? 32'h0000_0000 : 32'hFFFF_FFFF;
            tick(1);
            if (ecnt == 1040) begin
                check("s2_en_late", 32'(strap_en), 32'd1);
                check("s2_timeout_before", 32'(strap_timeout), 32'd0);
            end
        end
        check("s2_pending", 32'(sb.size()), 32'd0);
        check("s2_timeout_held", 32'(strap_timeout), 32'd1);

        // Scenario 4: resample from DONE; old data/timeout held until the new capture.
        gpio_in = 32'hDEAD_BEEF;
        tick(4);
        strap_resample = 1'b1;
        tick(1);
        r = ecnt;
        strap_resample = 1'b0;
        sb.push_back('{data: 32'hDEAD_BEEF, to: 1'b0, edge_n: r + 24});
        tick(5);
        check("s4_en", 32'(strap_en), 32'd1);
        check("s4_busy", 32'(strap_busy), 32'd1);
        check("s4_old_data", strap_sample_data, 32'hFFFF_FFFF);
        check("s4_old_timeout", 32'(strap_timeout), 32'd1);
        wait_edge(r + 19);
        strap_resample = 1'b1;
        tick(1);
        strap_resample = 1'b0;
        wait_edge(r + 30);
        check("s4_pending", 32'(sb.size()), 32'd0);
        check("s4_busy_done", 32'(strap_busy), 32'd0);
        check("s4_en_done", 32'(strap_en), 32'd0);
        check("s4_data_held", strap_sample_data, 32'hDEAD_BEEF);

        // Scenario 3: glitch driven after edge 20 reaches the sample in TRACK cycle index 5,
        // restarting the run; capture moves 6 cycles later than scenario 1.
        gpio_in = 32'h1234_5678;
        do_reset();
        sb.push_back('{data: 32'h1234_5678, to: 1'b0, edge_n: 31});
        while (ecnt < 34) begin
            gpio_in = (ecnt == 20) ? 32'h1234_5679 : 32'h1234_5678;
            tick(1);
        end
        check("s3_pending", 32'(sb.size()), 32'd0);
        check("s3_timeout", 32'(strap_timeout), 32'd0);

        tick(3);
        check("final_queue", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at edge %0d", ecnt);
        $fatal(1, "watchdog");
    end

endmodule
